// File: rtl/bitwise_pkg.sv
// Shared definitions for the bit-serial logic driver: op encodings,
// FSM state type and a one-bit reference of the slice function.
package bitwise_pkg;

    localparam logic [1:0] OP_PASSB = 2'b00;
    localparam logic [1:0] OP_XOR   = 2'b01;
    localparam logic [1:0] OP_AND   = 2'b10;
    localparam logic [1:0] OP_OR    = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // What the bitwise slice produces for one bit position.
    function automatic logic logic_bit(input logic [1:0] op, input logic a, input logic b);
        logic q;
        case (op)
            OP_PASSB: q = b;
            OP_XOR:   q = a ^ b;
            OP_AND:   q = a & b;
            default:  q = a | b;
        endcase
        return q;
    endfunction

endpackage

// File: rtl/bitserial_logic_driver_if.sv
// Request/response bus of the bit-serial logic driver.
// Handshake: a transfer happens on a rising clk edge where valid && ready;
// the source holds valid and its payload stable until that edge, and the
// sink may drive ready independently of valid.
interface bitserial_logic_driver_if #(
    parameter int WIDTH = 8
);
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_q;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_q
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_q
    );
endinterface

// File: rtl/bitserial_shreg.sv
// WIDTH-bit register with parallel load and right shift (new bit enters
// at the MSB). Load has priority over shift.
module bitserial_shreg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    input  logic             sin,
    output logic [WIDTH-1:0] q
);

    // Load or shift-right storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift) begin
            q <= {sin, q[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/bitserial_logic_driver.sv
// Bit-serial front end for a 1-bit bitwise slice: accepts a WIDTH-bit
// request, feeds the slice LSB-first with dual-rail op selects, collects
// the slice output into a result word and returns it.
// Optional feature: define LOGIC_SELFCHECK_EN to add a parallel reference
// that flags a wrong result on err (sticky until next accept or reset).
module bitserial_logic_driver
    import bitwise_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    bitserial_logic_driver_if.slave  bus,
    output logic                     op1,
    output logic                     nop1,
    output logic                     op0,
    output logic                     nop0,
    output logic                     sa,
    output logic                     sb,
    input  logic                     sq,
    output logic                     err,
    output state_t                   dbg_state
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             op1_r, op0_r;
    logic             req_ready_r, rsp_valid_r;
    logic [WIDTH-1:0] a_q, b_q, res_q;
    logic             accept, shifting;

    assign accept   = (state == IDLE) && bus.req_valid;
    assign shifting = (state == SHIFT);

    bitserial_shreg #(.WIDTH(WIDTH)) u_a (
        .clk(clk), .rst_n(rst_n), .load(accept), .shift(shifting),
        .din(bus.req_a), .sin(1'b0), .q(a_q)
    );

    bitserial_shreg #(.WIDTH(WIDTH)) u_b (
        .clk(clk), .rst_n(rst_n), .load(accept), .shift(shifting),
        .din(bus.req_b), .sin(1'b0), .q(b_q)
    );

    // Result is cleared on accept so each op starts from a known word.
    bitserial_shreg #(.WIDTH(WIDTH)) u_res (
        .clk(clk), .rst_n(rst_n), .load(accept), .shift(shifting),
        .din('0), .sin(sq), .q(res_q)
    );

    // Upper operand bits are only shift storage; they leave through bit 0.
    logic unused_bits;
    assign unused_bits = ^{a_q[WIDTH-1:1], b_q[WIDTH-1:1]};

    // Control FSM with registered handshake and op-select outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            op1_r       <= 1'b0;
            op0_r       <= 1'b0;
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        {op1_r, op0_r} <= bus.req_op;
                        cnt            <= '0;
                        req_ready_r    <= 1'b0;
                        state          <= SHIFT;
                    end
                end
                SHIFT: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        cnt            <= '0;
                        {op1_r, op0_r} <= 2'b00;
                        rsp_valid_r    <= 1'b1;
                        state          <= DONE;
                    end
                end
                DONE: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        req_ready_r <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign op1           = op1_r;
    assign nop1          = ~op1_r;
    assign op0           = op0_r;
    assign nop0          = ~op0_r;
    assign sa            = shifting & a_q[0];
    assign sb            = shifting & b_q[0];
    assign bus.req_ready = req_ready_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_q     = res_q;
    assign dbg_state     = state;

`ifdef LOGIC_SELFCHECK_EN
    logic [1:0]       op_lat;
    logic [WIDTH-1:0] a_lat, b_lat, exp_word, res_next;
    logic             err_r;

    assign res_next = {sq, res_q[WIDTH-1:1]};

    // Parallel reference word from the latched request
    always_comb begin
        exp_word = '0;
        for (int i = 0; i < WIDTH; i++) begin
            exp_word[i] = logic_bit(op_lat, a_lat[i], b_lat[i]);
        end
    end

    // Latch request copies; compare the final word as DONE is entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_lat <= 2'b00;
            a_lat  <= '0;
            b_lat  <= '0;
            err_r  <= 1'b0;
        end else if (accept) begin
            op_lat <= bus.req_op;
            a_lat  <= bus.req_a;
            b_lat  <= bus.req_b;
            err_r  <= 1'b0;
        end else if (shifting && (cnt == LAST)) begin
            err_r  <= (res_next != exp_word);
        end
    end

    assign err = err_r;
`else
    assign err = 1'b0;
`endif

endmodule
